// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage RV32 core.
// It drives the stall and flush controls for IF/ID, ID/EX and EX/MEM, and the PC enable.
// It resolves three cases:
//   - load-use hazards, by inserting one bubble;
//   - EX-stage redirects, by flushing the wrong-path instructions;
//   - multi-cycle EX operations, with a RUN/MC_WAIT state machine that has a timeout.
// It also keeps two saturating performance counters.
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    output logic             pc_en,
    output logic             pc_sel_redir,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // The MC counter must be able to hold MC_TIMEOUT itself.
    localparam int MC_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [MC_W-1:0] MC_LIMIT = MC_W'(MC_TIMEOUT);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [MC_W-1:0] mc_cnt_reg;
    logic [MC_W-1:0] mc_cnt_next;
    logic            timeout_set;
    logic            load_use;
    logic            redirect_flush;

    // Detect a load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Register the state and the multi-cycle elapsed-cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            mc_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            mc_cnt_reg <= mc_cnt_next;
        end
    end

    // Compute the next state.
    // A redirect kills a wrong-path mc_start.
    // A start with a same-cycle done behaves as a one-cycle op.
    always_comb begin
        state_next  = state_reg;
        mc_cnt_next = mc_cnt_reg;
        timeout_set = 1'b0;
        case (state_reg)
            RUN: begin
                if (!ex_redirect && ex_mc_start && !ex_mc_done) begin
                    state_next  = MC_WAIT;
                    mc_cnt_next = MC_W'(1);
                end
            end
            MC_WAIT: begin
                if (ex_mc_done) begin
                    state_next  = RUN;
                    mc_cnt_next = '0;
                end else begin
                    mc_cnt_next = mc_cnt_reg + 1'b1;
                    if (mc_cnt_next >= MC_LIMIT) begin
                        // The unit is presumed hung: drop its result and resume.
                        timeout_set = 1'b1;
                        state_next  = RUN;
                        mc_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next  = RUN;
                mc_cnt_next = '0;
            end
        endcase
    end

    // Drive the pipeline controls combinationally from the state and inputs.
    // The chosen pairings never stall and flush the same register at once.
    always_comb begin
        pc_en          = 1'b1;
        pc_sel_redir   = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        redirect_flush = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ex_redirect) begin
                        pc_sel_redir   = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        redirect_flush = 1'b1;
                    end else if (ex_mc_start && !ex_mc_done) begin
                        pc_en        = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (ex_mc_start) begin
                        // A one-cycle multi-cycle op: its result advances normally.
                        pc_en = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (!ex_mc_done) begin
                        pc_en        = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                    pc_en = 1'b1;
                end
            endcase
        end
    end

    // Set the sticky timeout flag. Only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mc_timeout <= 1'b0;
        end else if (timeout_set) begin
            mc_timeout <= 1'b1;
        end
    end

    // Count stalled cycles, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Count redirect flushes, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_events <= '0;
        end else if (redirect_flush && (flush_events != {CNT_W{1'b1}})) begin
            flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl.
// It drives two instances with the same inputs: one uses the default timeout, the other a short one.
// The "sel" field of each record chooses which instance is compared.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    // Control vector bit order: {pc_en, pc_sel_redir, if_id_stall, if_id_flush,
    //                            id_ex_stall, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] C_RUN = 7'b1000000;
    localparam logic [6:0] C_LU  = 7'b0010010;
    localparam logic [6:0] C_RED = 7'b1101010;
    localparam logic [6:0] C_MC  = 7'b0010101;
    localparam logic [6:0] C_RST = 7'b0001011;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       mrd;
        logic       redir;
        logic       mcs;
        logic       mcd;
        logic [6:0] exp_ctrl;
        logic       exp_to;
        logic       sel;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic ex_redirect = 1'b0, ex_mc_start = 1'b0, ex_mc_done = 1'b0;

    logic [6:0] ctrl0, ctrl1;
    logic       to0, to1;
    logic [CNT_W-1:0] sc0, sc1, fe0, fe1;

    int n_cmp = 0;
    int n_fail = 0;
    int m_stall = 0;
    int m_flush = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .pc_en(ctrl0[6]), .pc_sel_redir(ctrl0[5]), .if_id_stall(ctrl0[4]),
        .if_id_flush(ctrl0[3]), .id_ex_stall(ctrl0[2]), .id_ex_flush(ctrl0[1]),
        .ex_mem_flush(ctrl0[0]), .mc_timeout(to0), .stall_cycles(sc0), .flush_events(fe0)
    );

    hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(CNT_W)) dut4 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .pc_en(ctrl1[6]), .pc_sel_redir(ctrl1[5]), .if_id_stall(ctrl1[4]),
        .if_id_flush(ctrl1[3]), .id_ex_stall(ctrl1[2]), .id_ex_flush(ctrl1[1]),
        .ex_mem_flush(ctrl1[0]), .mc_timeout(to1), .stall_cycles(sc1), .flush_events(fe1)
    );

    function automatic vec_t mk(logic rst, logic [4:0] rs1, logic use1, logic [4:0] rs2,
                                logic use2, logic [4:0] rd, logic mrd, logic redir,
                                logic mcs, logic mcd, logic [6:0] ctrl, logic to, logic sel);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
        v.rd = rd; v.mrd = mrd; v.redir = redir; v.mcs = mcs; v.mcd = mcd;
        v.exp_ctrl = ctrl; v.exp_to = to; v.sel = sel;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp_v, input int idx);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and queue its expectation.
    // Then pop the expectation and compare it against the outputs mid-cycle.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        logic [6:0] c;
        logic t;
        int s, f;
        @(posedge clock);
        #1;
        reset = v.rst; id_rs1 = v.rs1; id_use_rs1 = v.use1; id_rs2 = v.rs2;
        id_use_rs2 = v.use2; ex_rd = v.rd; ex_mem_read = v.mrd; ex_redirect = v.redir;
        ex_mc_start = v.mcs; ex_mc_done = v.mcd;
        sb.push_back(v);
        if (v.rst) begin
            m_stall = 0;
            m_flush = 0;
        end
        @(negedge clock);
        e = sb.pop_front();
        c = e.sel ? ctrl1 : ctrl0;
        t = e.sel ? to1 : to0;
        s = int'(e.sel ? sc1 : sc0);
        f = int'(e.sel ? fe1 : fe0);
        check("ctrl", int'(c), int'(e.exp_ctrl), idx);
        check("mc_timeout", int'(t), int'(e.exp_to), idx);
        check("stall_cycles", s, m_stall, idx);
        check("flush_events", f, m_flush, idx);
        check("stall_flush_conflict", int'((c[4] & c[3]) | (c[2] & c[1])), 0, idx);
        $display("step %0d rst=%0b redir=%0b mcs=%0b mcd=%0b lu_in=%0b ctrl=%07b to=%0b sc=%0d fe=%0d",
                 idx, e.rst, e.redir, e.mcs, e.mcd, e.mrd, c, t, s, f);
        if (!e.rst) begin
            if (!e.exp_ctrl[6]) m_stall++;
            if (e.exp_ctrl[5]) m_flush++;
        end
    endtask

    initial begin
        // Single-cycle behaviour table, checked on the default-timeout instance.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0));  // reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));  // idle
        tbl.push_back(mk(0, 5, 1, 2, 1, 5, 1, 0, 0, 0, C_LU,  0, 0));  // load x5, rs1=5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));  // one bubble only
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, C_RUN, 0, 0));  // rd=x0
        tbl.push_back(mk(0, 3, 1, 7, 0, 7, 1, 0, 0, 0, C_RUN, 0, 0));  // rs2 match, unused
        tbl.push_back(mk(0, 3, 1, 7, 1, 7, 1, 0, 0, 0, C_LU,  0, 0));  // rs2 match, used
        tbl.push_back(mk(0, 7, 1, 7, 1, 7, 0, 0, 0, 0, C_RUN, 0, 0));  // not a load
        tbl.push_back(mk(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, C_RED, 0, 0));  // redirect beats load_use
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RED, 0, 0));  // redirect kills mc_start
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));  // still RUN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0));  // one-cycle mc op
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));  // still RUN
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Multi-cycle op: done arrives after five wait cycles, so there are six stalls in total.
        // A redirect and a load_use during the wait are ignored.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0), 100);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MC,  0, 0), 101);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,  0, 0), 102);
        step(mk(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, C_MC,  0, 0), 103);
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC, 0, 0), 104 + i);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0), 107);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0), 108);

        // Timeout with MC_TIMEOUT=4: there are four stall cycles, then RUN resumes with a sticky flag.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 1), 200);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MC,  0, 1), 201);
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC, 0, 1), 202 + i);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 1), 205);
        step(mk(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, C_LU,  1, 1), 206);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 1, 1), 207);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 1), 208);

        // Reset during MC_WAIT: outputs and counters clear immediately, and RUN follows.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MC,  0, 0), 300);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,  0, 0), 301);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,  0, 0), 302);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0), 303);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0), 304);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0), 305);

        check("scoreboard_empty", sb.size(), 0, 999);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
